// File: rtl/alu_pkg.sv
// Shared ALU encodings used by the ALU-sharing arbiter and its neighbours.
//   alu_op_e   : 4-bit ALU operation codes (NOP drives a zero result)
//   flag_sel_e : 3-bit comparison flag select
package alu_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'b0000,
    AluSub = 4'b0001,
    AluSll = 4'b0010,
    AluXor = 4'b0011,
    AluSrl = 4'b0100,
    AluSra = 4'b0101,
    AluOr  = 4'b0110,
    AluAnd = 4'b0111,
    AluLui = 4'b1000,
    AluNop = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    FlagEq  = 3'd0,
    FlagNe  = 3'd1,
    FlagLt  = 3'd2,
    FlagGe  = 3'd3,
    FlagLtu = 3'd4,
    FlagGeu = 3'd5
  } flag_sel_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of every request, response and ALU-side signal of alu_share_arbiter.
//   slave  : the arbiter (consumes requests, drives responses and the ALU bus)
//   master : the surroundings (requesters plus the ALU instance)
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [DATA_W-1:0] req0_opa_i;
  logic [DATA_W-1:0] req0_opb_i;
  logic [3:0]        req0_aluctrl_i;
  logic [2:0]        req0_flagsel_i;
  logic              rsp0_valid_o;
  logic              rsp0_ready_i;
  logic [DATA_W-1:0] rsp0_result_o;
  logic              rsp0_flag_o;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [DATA_W-1:0] req1_opa_i;
  logic [DATA_W-1:0] req1_opb_i;
  logic [3:0]        req1_aluctrl_i;
  logic [2:0]        req1_flagsel_i;
  logic              rsp1_valid_o;
  logic              rsp1_ready_i;
  logic [DATA_W-1:0] rsp1_result_o;
  logic              rsp1_flag_o;

  logic [DATA_W-1:0] alu_opa_o;
  logic [DATA_W-1:0] alu_opb_o;
  logic [3:0]        alu_ctrl_o;
  logic [2:0]        alu_flagsel_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              alu_flag_i;

  modport slave (
    input  req0_valid_i, req0_opa_i, req0_opb_i, req0_aluctrl_i, req0_flagsel_i, rsp0_ready_i,
    input  req1_valid_i, req1_opa_i, req1_opb_i, req1_aluctrl_i, req1_flagsel_i, rsp1_ready_i,
    input  alu_result_i, alu_flag_i,
    output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_flag_o,
    output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_flag_o,
    output alu_opa_o, alu_opb_o, alu_ctrl_o, alu_flagsel_o
  );

  modport master (
    output req0_valid_i, req0_opa_i, req0_opb_i, req0_aluctrl_i, req0_flagsel_i, rsp0_ready_i,
    output req1_valid_i, req1_opa_i, req1_opb_i, req1_aluctrl_i, req1_flagsel_i, rsp1_ready_i,
    output alu_result_i, alu_flag_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_flag_o,
    input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_flag_o,
    input  alu_opa_o, alu_opb_o, alu_ctrl_o, alu_flagsel_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   elig_i[1:0]   : eligible requesters
//   gnt_o[1:0]    : one-hot (or zero) grant, combinational from elig_i
module rr_arb2 #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the requester that wins when both are eligible.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = elig_i;
    if (&elig_i) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
    // Hand priority to the loser; hold it when nobody is granted.
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= RR_INIT[0];
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and the
// branch/address unit (requester 1). A granted op is driven onto the ALU bus and
// its result/flag captured into that requester's 1-deep response buffer, held
// until the requester takes it.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : request/response handshakes and the ALU operand/result bus
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RR_INIT = 0
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  alu_share_arbiter_if.slave  bus
);

  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic [1:0]        rsp_ready;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q [2];
  logic [DATA_W-1:0] rsp_result_d [2];
  logic [1:0]        rsp_flag_q, rsp_flag_d;

  assign rsp_ready = {bus.rsp1_ready_i, bus.rsp0_ready_i};

  // A requester may issue if its response slot is empty or drains this cycle.
  assign elig[0] = bus.req0_valid_i & (~rsp_valid_q[0] | rsp_ready[0]);
  assign elig[1] = bus.req1_valid_i & (~rsp_valid_q[1] | rsp_ready[1]);

  rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_rr_arb2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  assign bus.req0_ready_o = gnt[0];
  assign bus.req1_ready_o = gnt[1];

  // Idle cycles park the bus on requester 0 with NOP so requester 1's data
  // never toggles the ALU inputs unless it is actually granted.
  always_comb begin
    bus.alu_opa_o     = bus.req0_opa_i;
    bus.alu_opb_o     = bus.req0_opb_i;
    bus.alu_ctrl_o    = AluNop;
    bus.alu_flagsel_o = bus.req0_flagsel_i;
    if (gnt[1]) begin
      bus.alu_opa_o     = bus.req1_opa_i;
      bus.alu_opb_o     = bus.req1_opb_i;
      bus.alu_ctrl_o    = bus.req1_aluctrl_i;
      bus.alu_flagsel_o = bus.req1_flagsel_i;
    end else if (gnt[0]) begin
      bus.alu_ctrl_o    = bus.req0_aluctrl_i;
    end
  end

  // Grant overrides drain, so drain+refill keeps valid high with no bubble.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rsp_valid_d[k]  = gnt[k] | (rsp_valid_q[k] & ~rsp_ready[k]);
      rsp_result_d[k] = gnt[k] ? bus.alu_result_i : rsp_result_q[k];
      rsp_flag_d[k]   = gnt[k] ? bus.alu_flag_i : rsp_flag_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 2'b00;
      rsp_flag_q  <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        rsp_result_q[k] <= '0;
      end
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_flag_q  <= rsp_flag_d;
      for (int k = 0; k < 2; k++) begin
        rsp_result_q[k] <= rsp_result_d[k];
      end
    end
  end

  assign bus.rsp0_valid_o  = rsp_valid_q[0];
  assign bus.rsp0_result_o = rsp_result_q[0];
  assign bus.rsp0_flag_o   = rsp_flag_q[0];
  assign bus.rsp1_valid_o  = rsp_valid_q[1];
  assign bus.rsp1_result_o = rsp_result_q[1];
  assign bus.rsp1_flag_o   = rsp_flag_q[1];

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters: requester 0 is the execute stage and requester 1 is the branch/address unit. Each request is arbitrated round-robin and driven onto the ALU operand and control lines. The ALU result and flag are captured into a 1-deep response buffer per requester. Each response is held until that requester accepts it. The block sits between the decode/execute pipeline and the ALU instance.

Parameters:
DATA_W, 32, operand/result width
RR_INIT, 0, requester favoured first after reset (0 or 1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req0_valid_i  in  1  requester 0 has an op
req0_ready_o  out  1  requester 0 op accepted this cycle
req0_opa_i  in  DATA_W  operand A
req0_opb_i  in  DATA_W  operand B
req0_aluctrl_i  in  4  ALU operation code
req0_flagsel_i  in  3  flag select (EQ..GEU)
rsp0_valid_o  out  1  response buffered for requester 0
rsp0_ready_i  in  1  requester 0 consumes response
rsp0_result_o  out  DATA_W  buffered result
rsp0_flag_o  out  1  buffered flag
req1_* / rsp1_*  same set as requester 0, for requester 1
alu_opa_o  out  DATA_W  to ALU operand A
alu_opb_o  out  DATA_W  to ALU operand B
alu_ctrl_o  out  4  to ALU control
alu_flagsel_o  out  3  to ALU flag select
alu_result_i  in  DATA_W  from ALU
alu_flag_i  in  1  from ALU

Behaviour:
- Reset (async, rst_ni low):
  - rsp0_valid_o = rsp1_valid_o = 0.
  - rsp results and flags = 0.
  - Priority pointer = RR_INIT.
  - Reset mid-transaction drops any buffered response with no partial output.
- Eligibility: requester k is eligible when reqk_valid_i = 1 and (rspk_valid_o = 0 or rspk_ready_i = 1), i.e. its slot is empty or drains this cycle.
- Grant:
  - At most one grant per cycle, combinational from the eligible set.
  - If both are eligible, the pointer's requester wins. Otherwise the sole eligible requester wins. If none is eligible, there is no grant.
  - reqk_ready_o = 1 only for the granted requester.
  - reqk_ready_o never depends on the other requester's ready.
- Pointer update: after every grant the pointer moves to the non-granted requester. It is unchanged in cycles with no grant.
- ALU drive:
  - alu_* = granted requester's fields.
  - When there is no grant, alu_* = requester-0 fields with alu_ctrl_o = 4'b1111 (ALU default, result 0), so the ALU bus does not toggle on the other requester's data.
- Capture: on the grant edge, rspk_result_o <= alu_result_i, rspk_flag_o <= alu_flag_i, rspk_valid_o <= 1.
- Latency: request accepted in cycle N, response visible in cycle N+1. Throughput is one op per cycle total.
- Response hold: while rspk_valid_o = 1 and rspk_ready_i = 0, result and flag are stable and no new grant goes to k.
- Same-cycle drain + refill: the slot is rewritten and rspk_valid_o stays 1 (back-to-back responses, no bubble).
- Drain only: rspk_ready_i = 1 with no new grant gives rspk_valid_o <= 0.
- Ignored inputs:
  - rspk_ready_i while rspk_valid_o = 0 is ignored.
  - reqk_* fields are don't-care while reqk_valid_i = 0.
- Fairness: with both requesters continuously valid and draining, grants alternate strictly 0,1,0,1 (given RR_INIT=0).
- Width: no arithmetic in this block; operands pass through unmodified at DATA_W.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op codes: ADD=4'b0000, SUB=4'b0001, SLL=4'b0010, XOR=4'b0011, SRL=4'b0100, SRA=4'b0101, OR=4'b0110, AND=4'b0111, LUI=4'b1000, NOP=4'b1111.
  - Flag select codes: EQ=3'd0, NE=3'd1, LT=3'd2, GE=3'd3, LTU=3'd4, GEU=3'd5.
- One sub-module, rr_arb2: a 2-way round-robin grant with pointer register, async active-low reset, and a RR_INIT parameter.
- The response buffers and ALU mux stay in the top module.

Test Plan:
1. Single request: req0 ADD, A=5, B=7, rsp0_ready=1 -> req0_ready=1 in cycle N; rsp0_valid=1 with result=12 in N+1; alu_ctrl_o=4'b1111 in N+1.
2. Contention: both valid every cycle, both rsp_ready=1, RR_INIT=0 -> grants 0,1,0,1 over 4 cycles; no double grant in any cycle.
3. Backpressure: req1 SUB, A=B=9, flagsel EQ; rsp1_ready=0 for 3 cycles, req1 valid again with A=1 -> rsp1 holds flag=1 and result=0; req1_ready stays 0 until rsp1_ready=1, then the new op is granted the same cycle.
4. Drain+refill: rsp0_valid=1, rsp0_ready=1, req0 XOR 0xF0^0x0F in the same cycle -> rsp0_valid stays 1, result=0xFF the next cycle.
5. Reset mid-operation: rst_ni low during a grant cycle with rsp1_valid=1 -> both rsp_valid go 0 immediately (async). After release, RR_INIT priority holds on the first contention.
6. Flag path: req1 SUB, A=0xFFFFFFFF, B=1, flagsel LT -> rsp1_flag=1; the same op with flagsel LTU -> rsp1_flag=0.
